// File: rtl/fat_pkg.sv
// Shared definitions for the serial word framer: data width, FSM states,
// counter width default and the frame parity check.
package fat_pkg;

   localparam int W     = 5;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PAR
   } state_t;

   // Even parity: the XOR over all data bits and the parity bit must be zero.
   function automatic logic even_par_ok(input logic [W-1:0] word, input logic par);
      return ~((^word) ^ par);
   endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with registered storage; dout shows the head entry.
// The extra pointer bit separates full from empty.
module word_fifo #(
   parameter int W     = 5,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic         do_push;
   logic         do_pop;

   always_comb begin
      empty   = (wptr == rptr);
      full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      dout    = mem[rptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
            wptr              <= wptr + 1'b1;
         end
         if (do_pop) rptr <= rptr + 1'b1;
      end
   end

endmodule

// File: rtl/ser5_word_framer.sv
// Serial-to-word framer: assembles MSB-first data bits plus an even-parity bit,
// buffers good words in a FIFO and counts/flags bad frames and overflow.
module ser5_word_framer #(
   parameter int W     = fat_pkg::W,
   parameter int DEPTH = 2,
   parameter int CNT_W = fat_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sin_valid,
   input  logic             sin_sof,
   input  logic             sin,
   input  logic             word_ready,
   input  logic             clr,
   output logic [W-1:0]     word_out,
   output logic             word_valid,
   output logic             par_err,
   output logic             ovf,
   output logic [CNT_W-1:0] err_cnt
);

   import fat_pkg::*;

   localparam int IW = $clog2(W);

   state_t       state;
   logic [W-1:0] sreg;
   logic [IW-1:0] idx;
   logic         frame_done;
   logic         frame_good;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   logic         ovf_set;
   logic         err_set;

   // Handshake: a word transfers on every cycle where word_valid && word_ready;
   // word_out holds steady while word_valid is high and word_ready is low.
   always_comb begin
      frame_done = sin_valid && !sin_sof && (state == PAR);
      frame_good = even_par_ok(sreg, sin);
      pop        = word_valid && word_ready;
      push       = frame_done && frame_good && (!full || pop);
      ovf_set    = frame_done && frame_good && full && !pop;
      err_set    = frame_done && !frame_good;
      word_valid = !empty;
   end

   word_fifo #(
      .W    (W),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push),
      .din  (sreg),
      .pop  (pop),
      .full (full),
      .empty(empty),
      .dout (word_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         sreg    <= '0;
         idx     <= '0;
         par_err <= 1'b0;
         ovf     <= 1'b0;
         err_cnt <= '0;
      end else begin
         par_err <= err_set;

         // A set event in the same cycle as clr takes priority.
         if (ovf_set)  ovf <= 1'b1;
         else if (clr) ovf <= 1'b0;

         if (err_set) begin
            if (clr)                 err_cnt <= CNT_W'(1);
            else if (err_cnt != '1)  err_cnt <= err_cnt + 1'b1;
         end else if (clr) begin
            err_cnt <= '0;
         end

         // sof on any valid bit restarts framing, silently abandoning a partial frame.
         if (sin_valid) begin
            if (sin_sof) begin
               state <= DATA;
               sreg  <= {{(W-1){1'b0}}, sin};
               idx   <= IW'(W-2);
            end else begin
               case (state)
                  DATA: begin
                     sreg <= {sreg[W-2:0], sin};
                     if (idx == '0) state <= PAR;
                     else           idx   <= idx - 1'b1;
                  end
                  PAR:     state <= IDLE;
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ser5_word_framer.sv
// Directed bench for ser5_word_framer: one task per scenario, inline checks,
// single summary line at the end.
module tb_ser5_word_framer;

   logic       clk;
   logic       rst_n;
   logic       sin_valid;
   logic       sin_sof;
   logic       sin;
   logic       word_ready;
   logic       clr;
   logic [4:0] word_out;
   logic       word_valid;
   logic       par_err;
   logic       ovf;
   logic [7:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] exp_q[$];

   ser5_word_framer #(
      .W    (5),
      .DEPTH(2),
      .CNT_W(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sin_valid (sin_valid),
      .sin_sof   (sin_sof),
      .sin       (sin),
      .word_ready(word_ready),
      .clr       (clr),
      .word_out  (word_out),
      .word_valid(word_valid),
      .par_err   (par_err),
      .ovf       (ovf),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; the task returns at the next falling
   // edge, so outputs then reflect the rising edge that captured these inputs.
   task automatic drive_bit(input logic v, input logic s, input logic b);
      sin_valid = v;
      sin_sof   = s;
      sin       = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      sin_valid = 1'b0;
      sin_sof   = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [4:0] w, input logic p, input logic rdy_par);
      drive_bit(1'b1, 1'b1, w[4]);
      for (int i = 3; i >= 0; i--) drive_bit(1'b1, 1'b0, w[i]);
      word_ready = rdy_par;
      drive_bit(1'b1, 1'b0, p);
      sin_valid  = 1'b0;
      sin_sof    = 1'b0;
      word_ready = 1'b0;
   endtask

   task automatic pop_one();
      word_ready = 1'b1;
      idle(1);
      word_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(2);
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
      n_checks++; if (word_out !== 5'b00000) begin n_fail++; $display("FAIL reset_word_out: got %b expected 00000", word_out); end
      n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL reset_par_err: got %b expected 0", par_err); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_good_frame();
      send_frame(5'b11011, 1'b0, 1'b0);
      n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid: got %b expected 1", word_valid); end
      n_checks++; if (word_out !== 5'b11011) begin n_fail++; $display("FAIL good_word: got %b expected 11011", word_out); end
      n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL good_par_err: got %b expected 0", par_err); end
      idle(2);
      n_checks++; if (word_out !== 5'b11011) begin n_fail++; $display("FAIL good_hold: got %b expected 11011", word_out); end
      pop_one();
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL good_popped: got %b expected 0", word_valid); end
   endtask

   task automatic test_bad_frame();
      send_frame(5'b11011, 1'b1, 1'b0);
      n_checks++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL bad_par_err: got %b expected 1", par_err); end
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL bad_no_word: got %b expected 0", word_valid); end
      n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL bad_err_cnt: got %0d expected 1", err_cnt); end
      idle(1);
      n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL bad_pulse_width: got %b expected 0", par_err); end
   endtask

   task automatic test_stall();
      drive_bit(1'b1, 1'b1, 1'b1);
      drive_bit(1'b0, 1'b0, 1'b1);
      drive_bit(1'b1, 1'b0, 1'b0);
      drive_bit(1'b0, 1'b1, 1'b0);
      drive_bit(1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 1'b0, 1'b0);
      drive_bit(1'b0, 1'b0, 1'b0);
      drive_bit(1'b1, 1'b0, 1'b1);
      drive_bit(1'b0, 1'b0, 1'b0);
      drive_bit(1'b1, 1'b0, 1'b1);
      sin_valid = 1'b0;
      n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", word_valid); end
      n_checks++; if (word_out !== 5'b10101) begin n_fail++; $display("FAIL stall_word: got %b expected 10101", word_out); end
      n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL stall_par_err: got %b expected 0", par_err); end
      pop_one();
   endtask

   task automatic test_abort();
      drive_bit(1'b1, 1'b1, 1'b1);
      drive_bit(1'b1, 1'b0, 1'b0);
      drive_bit(1'b1, 1'b0, 1'b1);
      send_frame(5'b01110, 1'b1, 1'b0);
      n_checks++; if (word_out !== 5'b01110) begin n_fail++; $display("FAIL abort_word: got %b expected 01110", word_out); end
      n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL abort_par_err: got %b expected 0", par_err); end
      n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL abort_err_cnt: got %0d expected 1", err_cnt); end
      pop_one();
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL abort_single_word: got %b expected 0", word_valid); end
   endtask

   task automatic test_overflow();
      logic [4:0] exp;
      send_frame(5'b00001, 1'b1, 1'b0);
      exp_q.push_back(5'b00001);
      send_frame(5'b00010, 1'b1, 1'b0);
      exp_q.push_back(5'b00010);
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", ovf); end
      send_frame(5'b00100, 1'b1, 1'b0);
      n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf); end
      word_ready = 1'b1;
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_valid: got %b expected 1", word_valid); end
         n_checks++; if (word_out !== exp) begin n_fail++; $display("FAIL ovf_drain_word: got %b expected %b", word_out, exp); end
         idle(1);
      end
      word_ready = 1'b0;
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected 0", word_valid); end
      n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
      n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL err_cnt_clr: got %0d expected 0", err_cnt); end
   endtask

   task automatic test_full_push_pop();
      send_frame(5'b00001, 1'b1, 1'b0);
      send_frame(5'b00010, 1'b1, 1'b0);
      send_frame(5'b11111, 1'b1, 1'b1);
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b expected 0", ovf); end
      n_checks++; if (word_out !== 5'b00010) begin n_fail++; $display("FAIL fpp_head: got %b expected 00010", word_out); end
      pop_one();
      n_checks++; if (word_out !== 5'b11111) begin n_fail++; $display("FAIL fpp_last: got %b expected 11111", word_out); end
      n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL fpp_last_valid: got %b expected 1", word_valid); end
      pop_one();
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %b expected 0", word_valid); end
   endtask

   task automatic test_reset_midframe();
      send_frame(5'b00111, 1'b1, 1'b0);
      send_frame(5'b11011, 1'b1, 1'b0);
      drive_bit(1'b1, 1'b1, 1'b1);
      drive_bit(1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", word_valid); end
      n_checks++; if (word_out !== 5'b00000) begin n_fail++; $display("FAIL rst_mid_word: got %b expected 00000", word_out); end
      n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_par_err: got %b expected 0", par_err); end
      n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_mid_err_cnt: got %0d expected 0", err_cnt); end
      drive_bit(1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 1'b0, 1'b0);
      drive_bit(1'b1, 1'b0, 1'b1);
      idle(1);
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale: got %b expected 0", word_valid); end
      send_frame(5'b10000, 1'b1, 1'b0);
      n_checks++; if (word_out !== 5'b10000) begin n_fail++; $display("FAIL rst_mid_next_word: got %b expected 10000", word_out); end
      pop_one();
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_one_word: got %b expected 0", word_valid); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 255; i++) send_frame(5'b10110, 1'b0, 1'b0);
      n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_reach: got %0d expected 255", err_cnt); end
      send_frame(5'b00001, 1'b0, 1'b0);
      n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", err_cnt); end
      n_checks++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL sat_par_err: got %b expected 1", par_err); end
      clr = 1'b1;
      send_frame(5'b00011, 1'b1, 1'b0);
      clr = 1'b0;
      n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_vs_err: got %0d expected 1", err_cnt); end
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL sat_no_word: got %b expected 0", word_valid); end
   endtask

   initial begin
      rst_n      = 1'b0;
      sin_valid  = 1'b0;
      sin_sof    = 1'b0;
      sin        = 1'b0;
      word_ready = 1'b0;
      clr        = 1'b0;
      test_reset();
      test_good_frame();
      test_bad_frame();
      test_stall();
      test_abort();
      test_overflow();
      test_full_push_pop();
      test_reset_midframe();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ser5_word_framer.md
# ser5_word_framer

Upstream feeder for the 5-bit combinational transform stage. It receives a serial bit stream, assembles 5-bit words (MSB first) followed by an even-parity bit, and checks the parity. Good words are buffered in a small FIFO and presented to the downstream stage over a valid/ready handshake. Bad frames are dropped and counted, and buffer overflow is flagged.

## Interface
- W, 5, data word width; the downstream stage input width
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- CNT_W, 8, parity-error counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- sin_valid  input  1  qualifies sin/sin_sof this cycle
- sin_sof  input  1  start of frame; marks the first data bit
- sin  input  1  serial data bit
- word_ready  input  1  downstream accepts word_out
- clr  input  1  clears ovf and err_cnt (synchronous)
- word_out  output  W  head-of-FIFO word; drives the downstream x
- word_valid  output  1  FIFO non-empty
- par_err  output  1  one-cycle pulse on a parity-failed frame
- ovf  output  1  sticky; a good frame was dropped because the FIFO was full
- err_cnt  output  CNT_W  saturating count of parity-failed frames

## Operation
- Frame is W data bits (MSB first) then 1 parity bit. A frame is good when the XOR of all W+1 bits is 0.
- FSM states:
  - IDLE: sin_valid & sin_sof → DATA, with sin stored as bit W-1 and bit index = W-2. Valid bits without sof are ignored.
  - DATA: each valid bit shifts in. After bit 0 → PAR.
  - PAR: the next valid bit is the parity bit. Evaluate the frame → IDLE.
- sin_valid low: state, shift register and index hold.
- sin_sof asserted with a valid bit in DATA or PAR aborts the current frame silently (no pulse, no count). That bit starts a new frame as in IDLE.
- Good frame, FIFO not full (or full with a pop in the same cycle): push the word.
- Good frame, FIFO full, no pop: drop the word and set ovf.
- Bad frame: no push. par_err pulses and err_cnt increments, saturating at 2^CNT_W-1.
- Pop happens when word_valid & word_ready. word_out is the FIFO head and is stable while word_valid & !word_ready.
- clr clears ovf and err_cnt. If a set event lands in the same cycle, the set wins: ovf=1, and err_cnt=1 on a bad frame.
- Reset values: state IDLE, FIFO empty, word_valid 0, word_out 0, par_err 0, ovf 0, err_cnt 0.

## Timing
- Parity bit accepted at edge N. The push happens at edge N, so word_valid=1 and word_out is valid from cycle N+1.
- par_err is registered: high exactly in cycle N+1.
- Minimum frame: W+1 consecutive valid cycles, so back-to-back frames give one word per 6 cycles.
- FIFO throughput is one pop per cycle. Simultaneous push and pop on a full FIFO is legal, with no ovf.
- Simultaneous push and pop on an empty FIFO is not a bypass: the pushed word appears next cycle.
- rst_n low at any edge, including mid-frame or with a full FIFO, discards everything and returns to the reset values in the next cycle.

## Structure
- Shared package fat_pkg holds:
  - W
  - the state typedef (IDLE, DATA, PAR)
  - the CNT_W default
  - the function even_par_ok(word, par)
- Sub-module word_fifo: synchronous FIFO with parameters W and DEPTH, ports push/pop/full/empty/dout, and the same clk/rst_n. The framer instantiates it once.

## Test plan
- Good frame: sof with bits 1,1,0,1,1, parity 0 → word_out=5'b11011 and word_valid=1 one cycle after the parity bit; par_err stays 0.
- Bad frame: bits 1,1,0,1,1, parity 1 → no word; par_err pulses once; err_cnt=1.
- Stall and abort:
  - sin_valid gaps inside a frame of 10101/parity 1 → word 5'b10101 is still produced.
  - A new sof after 3 bits restarts the frame; only the second frame's word appears.
- Overflow: word_ready=0, send 3 good frames (00001, 00010, 00100) → first two are buffered and ovf=1. Raising word_ready pops 00001 then 00010, and ovf stays 1 until clr.
- Full push+pop: FIFO full, word_ready=1 in the same cycle a good frame 11111/parity 1 completes → no ovf, and 11111 becomes the last entry.
- Reset mid-frame and saturation:
  - rst_n=0 after 2 bits → all outputs 0 next cycle, and no stale word appears after a following good frame.
  - 256 bad frames → err_cnt holds at 255.
